// File: rtl/hs_npu_inference_ctrl_if.sv
// Handshake bundle between the host/DMA side and the NPU inference sequencer.
// The host drives job requests and datapath events; the sequencer drives strobes and status.
interface hs_npu_inference_ctrl_if;
  logic        start;
  logic        abort;
  logic [31:0] rows;
  logic        reuse_weights;
  logic        weight_push;
  logic        input_push;
  logic        out_valid;
  logic        result_ready;

  logic        flush_input_fifos;
  logic        flush_weight_fifos;
  logic        flush_output_fifos;
  logic        enable_weights;
  logic        bias_en;
  logic        start_input_gatekeeper;
  logic        start_output_gatekeeper;
  logic [31:0] enable_cycles;
  logic        output_fifo_ready;
  logic        output_fifo_reread;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, abort, rows, reuse_weights, weight_push, input_push,
           out_valid, result_ready,
    input  flush_input_fifos, flush_weight_fifos, flush_output_fifos,
           enable_weights, bias_en, start_input_gatekeeper,
           start_output_gatekeeper, enable_cycles, output_fifo_ready,
           output_fifo_reread, busy, done, error
  );

  modport slave (
    input  start, abort, rows, reuse_weights, weight_push, input_push,
           out_valid, result_ready,
    output flush_input_fifos, flush_weight_fifos, flush_output_fifos,
           enable_weights, bias_en, start_input_gatekeeper,
           start_output_gatekeeper, enable_cycles, output_fifo_ready,
           output_fifo_reread, busy, done, error
  );
endinterface

// File: rtl/hs_npu_inference_ctrl.sv
// Job sequencer for the NPU inference datapath: flush, weight/input load tracking,
// latch/gatekeeper strobes, result drain and a stall watchdog. All outputs registered.
module hs_npu_inference_ctrl #(
  parameter int SIZE     = 8,
  parameter int MAX_ROWS = 10,
  parameter int TIMEOUT  = 1024
) (
  input logic                    clk,
  input logic                    rst,
  hs_npu_inference_ctrl_if.slave bus
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int RCW = $clog2(SIZE + 1);

  typedef enum logic [3:0] {
    IDLE, FLUSH, LOAD_W, LATCH_W, LOAD_IN, RUN, DRAIN, DONE, ABORT
  } state_t;

  state_t         state;
  logic [31:0]    rows_q;
  logic [31:0]    cnt;
  logic           reuse_q;
  logic           w_valid;
  logic [WDW-1:0] wdog;
  logic [RCW-1:0] run_cnt;

  logic        flush_in, flush_w, flush_out;
  logic        en_w, bias, gk_in, gk_out;
  logic        fifo_rdy, busy, done, err;
  logic [31:0] en_cyc;

  logic wait_state, evt, timeout, abort_now;

  assign wait_state = (state == LOAD_W) || (state == LOAD_IN) || (state == DRAIN);
  assign evt        = ((state == LOAD_W)  && bus.weight_push) ||
                      ((state == LOAD_IN) && bus.input_push)  ||
                      ((state == DRAIN)   && bus.out_valid && fifo_rdy);
  assign timeout    = wait_state && !evt && (wdog == WDW'(TIMEOUT - 1));
  // ABORT is already heading home, so a held abort does not re-trigger it.
  assign abort_now  = bus.abort && (state != IDLE) && (state != ABORT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rows_q    <= '0;
      cnt       <= '0;
      reuse_q   <= 1'b0;
      w_valid   <= 1'b0;
      wdog      <= '0;
      run_cnt   <= '0;
      flush_in  <= 1'b0;
      flush_w   <= 1'b0;
      flush_out <= 1'b0;
      en_w      <= 1'b0;
      bias      <= 1'b0;
      gk_in     <= 1'b0;
      gk_out    <= 1'b0;
      fifo_rdy  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      en_cyc    <= '0;
    end else begin
      flush_in  <= 1'b0;
      flush_w   <= 1'b0;
      flush_out <= 1'b0;
      en_w      <= 1'b0;
      bias      <= 1'b0;
      gk_in     <= 1'b0;
      gk_out    <= 1'b0;
      fifo_rdy  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      // Any progress event or leaving the wait states restarts the stall count.
      wdog      <= (wait_state && !evt) ? wdog + 1'b1 : '0;

      if (abort_now || timeout) begin
        state     <= ABORT;
        err       <= 1'b1;
        flush_in  <= 1'b1;
        flush_w   <= 1'b1;
        flush_out <= 1'b1;
        w_valid   <= 1'b0;
        en_cyc    <= '0;
        cnt       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (bus.rows == '0 || bus.rows > 32'(MAX_ROWS) ||
                  (bus.reuse_weights && !w_valid)) begin
                err <= 1'b1;
              end else begin
                state     <= FLUSH;
                busy      <= 1'b1;
                rows_q    <= bus.rows;
                reuse_q   <= bus.reuse_weights;
                flush_in  <= 1'b1;
                flush_out <= 1'b1;
                flush_w   <= !bus.reuse_weights;
                en_cyc    <= bus.rows + 32'(SIZE - 1);
                if (!bus.reuse_weights) w_valid <= 1'b0;
              end
            end
          end

          FLUSH: begin
            cnt   <= '0;
            state <= reuse_q ? LOAD_IN : LOAD_W;
          end

          LOAD_W: begin
            if (bus.weight_push) begin
              if (cnt == 32'(SIZE - 1)) begin
                state   <= LATCH_W;
                cnt     <= '0;
                en_w    <= 1'b1;
                bias    <= 1'b1;
                w_valid <= 1'b1;
              end else begin
                cnt <= cnt + 32'd1;
              end
            end
          end

          LATCH_W: state <= LOAD_IN;

          LOAD_IN: begin
            if (bus.input_push) begin
              if (cnt == rows_q - 32'd1) begin
                state   <= RUN;
                cnt     <= '0;
                gk_in   <= 1'b1;
                run_cnt <= '0;
              end else begin
                cnt <= cnt + 32'd1;
              end
            end
          end

          // Output gatekeeper fires SIZE cycles after the input one; DRAIN follows it.
          RUN: begin
            run_cnt <= run_cnt + 1'b1;
            if (run_cnt == RCW'(SIZE - 1)) gk_out <= 1'b1;
            if (run_cnt == RCW'(SIZE)) begin
              state    <= DRAIN;
              fifo_rdy <= bus.result_ready;
            end
          end

          DRAIN: begin
            fifo_rdy <= bus.result_ready;
            if (bus.out_valid && fifo_rdy) begin
              if (cnt == rows_q - 32'd1) begin
                state    <= DONE;
                done     <= 1'b1;
                fifo_rdy <= 1'b0;
                en_cyc   <= '0;
                cnt      <= '0;
              end else begin
                cnt <= cnt + 32'd1;
              end
            end
          end

          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end

          ABORT: begin
            state <= IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.flush_input_fifos       = flush_in;
  assign bus.flush_weight_fifos      = flush_w;
  assign bus.flush_output_fifos      = flush_out;
  assign bus.enable_weights          = en_w;
  assign bus.bias_en                 = bias;
  assign bus.start_input_gatekeeper  = gk_in;
  assign bus.start_output_gatekeeper = gk_out;
  assign bus.enable_cycles           = en_cyc;
  assign bus.output_fifo_ready       = fifo_rdy;
  assign bus.output_fifo_reread      = 1'b0;
  assign bus.busy                    = busy;
  assign bus.done                    = done;
  assign bus.error                   = err;

endmodule
